// File: rtl/lstm_pkg.sv
// ============================================================================
// Module      : lstm_pkg
// Description : Shared Q-format helpers, gate indices and FSM encoding for the LSTM cell
// Revision    : 1.0
// ============================================================================
`default_nettype none

package lstm_pkg;

   localparam int Q_FRACT = 8;
   localparam int ONE     = 1 << Q_FRACT;
   localparam int HALF    = ONE / 2;

   localparam int G_F     = 0;
   localparam int G_I     = 1;
   localparam int G_C     = 2;
   localparam int G_O     = 3;
   localparam int N_GATES = 4;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MAC  = 3'd1,
      S_ACT  = 3'd2,
      S_CELL = 3'd3,
      S_HOUT = 3'd4,
      S_OUT  = 3'd5
   } state_t;

   function automatic int q_one(input int f);
      return 1 << f;
   endfunction

   // Clamp a wide signed value into a dw-bit signed range; caller truncates.
   function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int dw);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic int w_index(input int g, input int k, input int n_in);
      return g * (n_in + 2) + k;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lstm_act.sv
// ============================================================================
// Module      : lstm_act
// Description : Combinational hard sigmoid (tanh_mode=0) / hard tanh (tanh_mode=1)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module lstm_act
   import lstm_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int FRACT_WIDTH = 8
) (
   input  logic signed [DATA_WIDTH-1:0] a_in,
   input  logic                         tanh_mode,
   output logic signed [DATA_WIDTH-1:0] a_out
);

   localparam logic signed [DATA_WIDTH:0] c_one  = (DATA_WIDTH+1)'(q_one(FRACT_WIDTH));
   localparam logic signed [DATA_WIDTH:0] c_mone = -c_one;

   logic signed [DATA_WIDTH:0] w_x;
   logic signed [DATA_WIDTH:0] w_sig;

   always_comb begin
      w_x   = (DATA_WIDTH+1)'(a_in);
      w_sig = (w_x >>> 2) + (c_one >>> 1);
      a_out = a_in;
      if (tanh_mode) begin
         if (w_x > c_one)       a_out = DATA_WIDTH'(c_one);
         else if (w_x < c_mone) a_out = DATA_WIDTH'(c_mone);
      end else begin
         if (w_sig < 0)          a_out = '0;
         else if (w_sig > c_one) a_out = DATA_WIDTH'(c_one);
         else                    a_out = DATA_WIDTH'(w_sig);
      end
   end

endmodule

`default_nettype wire

// File: rtl/lstm_cell_seq.sv
// ============================================================================
// Module      : lstm_cell_seq
// Description : Sequential hidden-size-1 LSTM cell, one shared MAC multiplier over 4 gates
// Revision    : 1.0
// ============================================================================
`default_nettype none

module lstm_cell_seq
   import lstm_pkg::*;
#(
   parameter  int DATA_WIDTH  = 16,
   parameter  int FRACT_WIDTH = 8,
   parameter  int N_IN        = 2,
   localparam int AW          = $clog2(4 * (N_IN + 2))
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [N_IN*DATA_WIDTH-1:0]   in_x,
   input  logic                         in_seq_start,
   input  logic                         w_we,
   input  logic [AW-1:0]                w_addr,
   input  logic [DATA_WIDTH-1:0]        w_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        c_out,
   output logic [DATA_WIDTH-1:0]        h_out
);

   localparam int DW   = DATA_WIDTH;
   localparam int PW   = 2 * DW;
   localparam int ACCW = 2 * DW + $clog2(N_IN + 2);
   localparam int NW   = 4 * (N_IN + 2);
   localparam int KW   = $clog2(N_IN + 1);

   state_t state_q, state_d;

   logic signed [DW-1:0]   w_q   [NW];
   logic signed [DW-1:0]   w_d   [NW];
   logic signed [DW-1:0]   x_q   [N_IN];
   logic signed [DW-1:0]   x_d   [N_IN];
   logic signed [DW-1:0]   act_q [N_GATES];
   logic signed [DW-1:0]   act_d [N_GATES];
   logic [1:0]             gate_q, gate_d;
   logic [KW-1:0]          k_q, k_d;
   logic signed [ACCW-1:0] acc_q, acc_d;
   logic signed [PW-1:0]   fc_q, fc_d, ig_q, ig_d;
   logic signed [DW-1:0]   c_q, c_d, h_q, h_d;
   logic [DW-1:0]          c_out_q, c_out_d, h_out_q, h_out_d;
   logic                   out_valid_q, out_valid_d;
   // Old contents of a word overwritten on the accept edge, so that timestep still sees it.
   logic                   ovr_valid_q, ovr_valid_d;
   logic [AW-1:0]          ovr_addr_q, ovr_addr_d;
   logic signed [DW-1:0]   ovr_data_q, ovr_data_d;

   logic                   w_accept, w_k_last, w_addr_ok;
   logic [AW-1:0]          w_wt_addr, w_bias_addr;
   logic signed [DW-1:0]   w_wt, w_bias, w_op, w_pre, w_act_in, w_act_out, w_c_new, w_h_new;
   logic signed [PW-1:0]   w_prod, w_oh;
   logic signed [ACCW-1:0] w_acc_sum;
   logic                   w_act_mode;

   assign in_ready  = (state_q == S_IDLE) && rst;
   assign out_valid = out_valid_q;
   assign c_out     = c_out_q;
   assign h_out     = h_out_q;

   assign w_accept    = in_valid && in_ready;
   assign w_addr_ok   = (int'(w_addr) < NW);
   assign w_k_last    = (k_q == KW'(N_IN));
   assign w_wt_addr   = AW'(w_index(int'(gate_q), int'(k_q), N_IN));
   assign w_bias_addr = AW'(w_index(int'(gate_q), N_IN + 1, N_IN));
   assign w_wt   = (ovr_valid_q && ovr_addr_q == w_wt_addr)   ? ovr_data_q : w_q[w_wt_addr];
   assign w_bias = (ovr_valid_q && ovr_addr_q == w_bias_addr) ? ovr_data_q : w_q[w_bias_addr];

   always_comb begin
      w_op = h_q;
      for (int k = 0; k < N_IN; k++) begin
         if (int'(k_q) == k) w_op = x_q[k];
      end
   end

   // MAC step: the first element of each gate restarts from the scaled bias.
   assign w_prod    = PW'(w_wt) * PW'(w_op);
   assign w_acc_sum = ((k_q == '0) ? (ACCW'(w_bias) <<< FRACT_WIDTH) : acc_q) + ACCW'(w_prod);
   assign w_pre     = DW'(sat(64'(w_acc_sum) >>> FRACT_WIDTH, DW));

   assign w_act_in   = (state_q == S_HOUT) ? c_q : w_pre;
   assign w_act_mode = (state_q == S_HOUT) || (gate_q == 2'(G_C));

   lstm_act #(
      .DATA_WIDTH  (DW),
      .FRACT_WIDTH (FRACT_WIDTH)
   ) u_act (
      .a_in      (w_act_in),
      .tanh_mode (w_act_mode),
      .a_out     (w_act_out)
   );

   assign w_c_new = DW'(sat(64'(fc_q >>> FRACT_WIDTH) + 64'(ig_q >>> FRACT_WIDTH), DW));
   assign w_oh    = PW'(act_q[G_O]) * PW'(w_act_out);
   assign w_h_new = DW'(sat(64'(w_oh) >>> FRACT_WIDTH, DW));

   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (w_accept) state_d = S_MAC;
         S_MAC:   if (w_k_last && gate_q == 2'(G_O)) state_d = S_ACT;
         S_ACT:   state_d = S_CELL;
         S_CELL:  state_d = S_HOUT;
         S_HOUT:  state_d = S_OUT;
         S_OUT:   if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      w_d         = w_q;
      x_d         = x_q;
      act_d       = act_q;
      gate_d      = gate_q;
      k_d         = k_q;
      acc_d       = acc_q;
      fc_d        = fc_q;
      ig_d        = ig_q;
      c_d         = c_q;
      h_d         = h_q;
      c_out_d     = c_out_q;
      h_out_d     = h_out_q;
      out_valid_d = out_valid_q;
      ovr_valid_d = ovr_valid_q;
      ovr_addr_d  = ovr_addr_q;
      ovr_data_d  = ovr_data_q;
      case (state_q)
         S_IDLE: begin
            if (w_we && w_addr_ok) w_d[w_addr] = w_data;
            if (w_accept) begin
               for (int k = 0; k < N_IN; k++) x_d[k] = in_x[k*DW +: DW];
               gate_d      = '0;
               k_d         = '0;
               ovr_valid_d = w_we && w_addr_ok;
               ovr_addr_d  = w_addr;
               ovr_data_d  = w_q[w_addr];
               if (in_seq_start) begin
                  c_d = '0;
                  h_d = '0;
               end
            end
         end
         S_MAC: begin
            acc_d = w_acc_sum;
            if (w_k_last) begin
               act_d[gate_q] = w_act_out;
               k_d           = '0;
               gate_d        = gate_q + 2'd1;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_ACT: begin
            fc_d = PW'(act_q[G_F]) * PW'(c_q);
            ig_d = PW'(act_q[G_I]) * PW'(act_q[G_C]);
         end
         S_CELL: c_d = w_c_new;
         S_HOUT: begin
            h_d         = w_h_new;
            c_out_d     = c_q;
            h_out_d     = w_h_new;
            out_valid_d = 1'b1;
         end
         S_OUT: begin
            ovr_valid_d = 1'b0;
            if (out_ready) out_valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NW; i++)      w_q[i]   <= '0;
         for (int i = 0; i < N_IN; i++)    x_q[i]   <= '0;
         for (int i = 0; i < N_GATES; i++) act_q[i] <= '0;
         gate_q      <= '0;
         k_q         <= '0;
         acc_q       <= '0;
         fc_q        <= '0;
         ig_q        <= '0;
         c_q         <= '0;
         h_q         <= '0;
         c_out_q     <= '0;
         h_out_q     <= '0;
         out_valid_q <= 1'b0;
         ovr_valid_q <= 1'b0;
         ovr_addr_q  <= '0;
         ovr_data_q  <= '0;
      end else begin
         w_q         <= w_d;
         x_q         <= x_d;
         act_q       <= act_d;
         gate_q      <= gate_d;
         k_q         <= k_d;
         acc_q       <= acc_d;
         fc_q        <= fc_d;
         ig_q        <= ig_d;
         c_q         <= c_d;
         h_q         <= h_d;
         c_out_q     <= c_out_d;
         h_out_q     <= h_out_d;
         out_valid_q <= out_valid_d;
         ovr_valid_q <= ovr_valid_d;
         ovr_addr_q  <= ovr_addr_d;
         ovr_data_q  <= ovr_data_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lstm_cell_seq.sv
// ============================================================================
// Module      : tb_lstm_cell_seq
// Description : Scoreboard bench for lstm_cell_seq (DW=16, F=8, N_IN=2)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_lstm_cell_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_x = '0;
   logic        in_seq_start = 1'b0;
   logic        w_we = 1'b0;
   logic [3:0]  w_addr = '0;
   logic [15:0] w_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] c_out;
   logic [15:0] h_out;

   lstm_cell_seq #(
      .DATA_WIDTH  (16),
      .FRACT_WIDTH (8),
      .N_IN        (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_x         (in_x),
      .in_seq_start (in_seq_start),
      .w_we         (w_we),
      .w_addr       (w_addr),
      .w_data       (w_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .c_out        (c_out),
      .h_out        (h_out)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0]        exp_q[$];
   logic signed [15:0] wt[16];
   logic signed [15:0] mc, mh;
   int accept_cyc = 0;
   int accept_id  = 0;
   int lat_seen   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   function automatic longint sat16(input longint v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic longint hsig(input longint x);
      longint t;
      t = (x >>> 2) + 128;
      if (t < 0)   return 0;
      if (t > 256) return 256;
      return t;
   endfunction

   function automatic longint htanh(input longint x);
      if (x > 256)  return 256;
      if (x < -256) return -256;
      return x;
   endfunction

   // Reference timestep from the cell equations; updates mc/mh.
   task automatic model_step(input logic signed [15:0] x0, input logic signed [15:0] x1);
      longint acc, pre, a[4], cn, hn;
      for (int g = 0; g < 4; g++) begin
         acc = longint'(wt[g*4+3]) * 256 + longint'(wt[g*4]) * longint'(x0)
             + longint'(wt[g*4+1]) * longint'(x1) + longint'(wt[g*4+2]) * longint'(mh);
         pre  = sat16(acc >>> 8);
         a[g] = (g == 2) ? htanh(pre) : hsig(pre);
      end
      cn = sat16(((a[0] * longint'(mc)) >>> 8) + ((a[1] * a[2]) >>> 8));
      hn = sat16((a[3] * htanh(cn)) >>> 8);
      mc = 16'(cn);
      mh = 16'(hn);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      wait_idle("wr");
      w_we = 1'b1; w_addr = a; w_data = d;
      @(posedge clk); #1;
      w_we = 1'b0;
      wt[a] = d;
   endtask

   // Issue one timestep; optional same-edge write and optional fixed expectation.
   task automatic step(input logic signed [15:0] x0, input logic signed [15:0] x1, input logic ss,
                       input logic use_exp, input logic [15:0] ec, input logic [15:0] eh,
                       input logic push, input logic we, input logic [3:0] wa, input logic [15:0] wd);
      wait_idle("step");
      if (ss) begin mc = '0; mh = '0; end
      in_x = {x1, x0}; in_seq_start = ss; in_valid = 1'b1;
      w_we = we; w_addr = wa; w_data = wd;
      @(posedge clk); #1;
      in_valid = 1'b0; w_we = 1'b0;
      model_step(x0, x1);
      if (we) wt[wa] = wd;
      if (push) begin
         accept_cyc = cyc;
         accept_id++;
         exp_q.push_back(use_exp ? {ec, eh} : {mc, mh});
      end
   endtask

   logic ov_prev = 1'b0;
   always @(negedge clk) begin
      logic [31:0] e;
      if (out_valid && !ov_prev && accept_id != lat_seen) begin
         chk("latency", 32'(cyc - accept_cyc), 32'd15);
         chk("in_ready_in_out", {31'd0, in_ready}, 32'd0);
         lat_seen = accept_id;
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", {c_out, h_out}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("c_out", {16'd0, c_out}, {16'd0, e[31:16]});
            chk("h_out", {16'd0, h_out}, {16'd0, e[15:0]});
         end
      end
      ov_prev = out_valid;
   end

   initial begin
      int n;
      int ov_hits;
      for (int i = 0; i < 16; i++) wt[i] = '0;
      mc = '0; mh = '0;
      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_c_h", {c_out, h_out}, 32'd0);
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;

      // Test 1: all-zero weights
      step(16'sd0, 16'sd0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'd0, 16'd0);

      // Test 2: bias_c = 1.0 across a sequence and a restart
      wr(4'd11, 16'h0100);
      step(16'sd0, 16'sd0, 1'b1, 1'b1, 16'h0080, 16'h0040, 1'b1, 1'b0, 4'd0, 16'd0);
      step(16'sd0, 16'sd0, 1'b0, 1'b1, 16'h00C0, 16'h0060, 1'b1, 1'b0, 4'd0, 16'd0);
      step(16'sd0, 16'sd0, 1'b1, 1'b1, 16'h0080, 16'h0040, 1'b1, 1'b0, 4'd0, 16'd0);

      // Test 3: saturating g preactivation
      wr(4'd8, 16'h7FFF);
      wr(4'd9, 16'h7FFF);
      step(16'sh7FFF, 16'sh7FFF, 1'b1, 1'b1, 16'h0080, 16'h0040, 1'b1, 1'b0, 4'd0, 16'd0);

      // Write to bias_i on the accept edge: this step keeps the old value
      step(16'sd0, 16'sd0, 1'b1, 1'b1, 16'h0080, 16'h0040, 1'b1, 1'b1, 4'd7, 16'h0200);
      step(16'sd0, 16'sd0, 1'b1, 1'b1, 16'h0100, 16'h0080, 1'b1, 1'b0, 4'd0, 16'd0);

      // Random weights, chained steps
      for (int i = 0; i < 16; i++) wr(4'(i), 16'($signed($urandom_range(768, 0)) - 384));
      for (int s = 0; s < 4; s++)
         step(16'($signed($urandom_range(1024, 0)) - 512), 16'($signed($urandom_range(1024, 0)) - 512),
              (s == 0), 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 4'd0, 16'd0);

      // Test 4: backpressure
      wait_idle("bp");
      out_ready = 1'b0;
      step(16'sh0123, -16'sh0080, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 4'd0, 16'd0);
      n = 0;
      while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
      if (n >= 40) chk("bp_valid_timeout", 32'd0, 32'd1);
      in_valid = 1'b1; in_x = 32'h0100_0100; in_seq_start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_hold", {29'd0, out_valid, in_ready, 1'b0}, {29'd0, 1'b1, 1'b0, 1'b0});
         chk("bp_data", {c_out, h_out}, exp_q.size() != 0 ? exp_q[0] : 32'hDEAD_BEEF);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_seq_start = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
      @(posedge clk); #1;

      // Test 5: write during MAC is dropped
      wr(4'd8, 16'h0000);
      wr(4'd9, 16'h0000);
      wr(4'd10, 16'h0000);
      wr(4'd11, 16'h0040);
      step(16'sh0100, 16'sh0100, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 4'd0, 16'd0);
      repeat (3) @(posedge clk); #1;
      w_we = 1'b1; w_addr = 4'd11; w_data = 16'h4000;
      @(posedge clk); #1;
      w_we = 1'b0;
      step(16'sh0100, 16'sh0100, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 4'd0, 16'd0);

      // Test 6: reset mid-MAC aborts and clears everything
      step(16'sh0100, 16'sh0100, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 4'd0, 16'd0);
      repeat (4) @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 16; i++) wt[i] = '0;
      mc = '0; mh = '0;
      ov_hits = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (out_valid) ov_hits++;
      end
      chk("abort_no_valid", 32'(ov_hits), 32'd0);
      @(posedge clk); #1;
      step(16'sd0, 16'sd0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'd0, 16'd0);
      step(16'sd0, 16'sd0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'd0, 16'd0);

      // Drain
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
      chk("drain", 32'(exp_q.size()), 32'd0);
      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

`default_nettype wire
